// File: rtl/dram_pkg.sv
// ---------------------------------------------------------------------------
// Module      : dram_pkg
// Description : Shared DRAM read-port widths, requester IDs and command type.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package dram_pkg;

  localparam int DRAM_ADDR_W = 25;
  localparam int DRAM_DATA_W = 256;

  localparam int REQ_UDP  = 0;
  localparam int REQ_HOST = 1;

  typedef struct packed {
    logic [DRAM_ADDR_W-1:0] addr;
  } dram_cmd_t;

endpackage

`default_nettype wire

// File: rtl/rd_tag_fifo.sv
// ---------------------------------------------------------------------------
// Module      : rd_tag_fifo
// Description : In-order owner-tag FIFO with simultaneous push/pop, flags
//               and occupancy count. DEPTH must be a power of two.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module rd_tag_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 1,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign empty    = (r_count == '0);
  assign full     = (r_count == (AW+1)'(DEPTH));
  assign count    = r_count;
  assign pop_data = r_mem[r_rd_ptr];

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/dram_read_arbiter.sv
// ---------------------------------------------------------------------------
// Module      : dram_read_arbiter
// Description : Round-robin arbiter sharing the DRAM read command port and
//               routing in-order read data back to the owning requester.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module dram_read_arbiter
  import dram_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int ADDR_W          = DRAM_ADDR_W,
  parameter int DATA_W          = DRAM_DATA_W,
  parameter int MAX_OUTSTANDING = 16,
  localparam int ID_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      DRAM_Read_Enable,
  output logic [ADDR_W-1:0]         DRAM_Read_Addr,
  input  logic                      DRAM_Read_Ready,
  input  logic [DATA_W-1:0]         DRAM_Read_Data,
  input  logic                      DRAM_Read_Valid,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_data,
  output logic [CNT_W-1:0]          outstanding,
  output logic                      err_unexpected
);

  logic [ADDR_W-1:0]  w_addr [NUM_REQ];
  logic [ID_W-1:0]    r_ptr;
  logic               r_cmd_valid;
  logic [ADDR_W-1:0]  r_cmd_addr;
  logic [NUM_REQ-1:0] r_resp_valid;
  logic [DATA_W-1:0]  r_resp_data;
  logic               r_err;

  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [ID_W-1:0]    w_tag_out;
  logic               w_slot_free;
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_grant_id;
  logic               w_accept;
  logic               w_pop;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_addr_unpack
    assign w_addr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
  end

  // FIFO occupancy is the registered in-flight count; full equals the cap.
  assign w_slot_free = (!r_cmd_valid || DRAM_Read_Ready) && !w_fifo_full;

  always_comb begin
    int  idx;
    logic found;
    w_grant    = '0;
    w_grant_id = '0;
    found      = 1'b0;
    idx        = 0;
    if (w_slot_free) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = int'(r_ptr) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!found && req_valid[idx]) begin
          found        = 1'b1;
          w_grant[idx] = 1'b1;
          w_grant_id   = ID_W'(idx);
        end
      end
    end
  end

  assign w_accept = |w_grant;
  assign w_pop    = DRAM_Read_Valid && !w_fifo_empty;

  rd_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (ID_W)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_accept),
    .push_data (w_grant_id),
    .pop       (w_pop),
    .pop_data  (w_tag_out),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty),
    .count     (outstanding)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr        <= '0;
      r_cmd_valid  <= 1'b0;
      r_cmd_addr   <= '0;
      r_resp_valid <= '0;
      r_resp_data  <= '0;
      r_err        <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cmd_valid <= 1'b1;
        r_cmd_addr  <= w_addr[w_grant_id];
        r_ptr       <= (w_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_id + 1'b1;
      end else if (DRAM_Read_Ready) begin
        r_cmd_valid <= 1'b0;
      end

      r_resp_valid <= w_pop ? (NUM_REQ'(1) << w_tag_out) : '0;
      if (w_pop) r_resp_data <= DRAM_Read_Data;
      if (DRAM_Read_Valid && w_fifo_empty) r_err <= 1'b1;
    end
  end

  assign req_ready        = w_grant;
  assign DRAM_Read_Enable = r_cmd_valid;
  assign DRAM_Read_Addr   = r_cmd_addr;
  assign resp_valid       = r_resp_valid;
  assign resp_data        = r_resp_data;
  assign err_unexpected   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_dram_read_arbiter.sv
// ---------------------------------------------------------------------------
// Module      : tb_dram_read_arbiter
// Description : Randomized scoreboard bench for dram_read_arbiter.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dram_read_arbiter;

  localparam int N    = 2;
  localparam int AW   = 25;
  localparam int DW   = 256;
  localparam int MAXO = 16;
  localparam int CW   = $clog2(MAXO) + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_ready;
  logic            DRAM_Read_Enable;
  logic [AW-1:0]   DRAM_Read_Addr;
  logic            DRAM_Read_Ready;
  logic [DW-1:0]   DRAM_Read_Data;
  logic            DRAM_Read_Valid;
  logic [N-1:0]    resp_valid;
  logic [DW-1:0]   resp_data;
  logic [CW-1:0]   outstanding;
  logic            err_unexpected;

  dram_read_arbiter #(
    .NUM_REQ         (N),
    .ADDR_W          (AW),
    .DATA_W          (DW),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_addr         (req_addr),
    .req_ready        (req_ready),
    .DRAM_Read_Enable (DRAM_Read_Enable),
    .DRAM_Read_Addr   (DRAM_Read_Addr),
    .DRAM_Read_Ready  (DRAM_Read_Ready),
    .DRAM_Read_Data   (DRAM_Read_Data),
    .DRAM_Read_Valid  (DRAM_Read_Valid),
    .resp_valid       (resp_valid),
    .resp_data        (resp_data),
    .outstanding      (outstanding),
    .err_unexpected   (err_unexpected)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          id;
    logic [DW-1:0] data;
  } resp_t;

  resp_t resp_q[$];
  int    owner_q[$];
  int    cyc = 0;
  int    total = 0;
  int    bad = 0;

  // Reference state: what the arbiter should hold after the coming edge.
  int          m_ptr;
  int          m_out;
  bit          m_en;
  logic [AW-1:0] m_addr;
  bit          m_err;
  bit          m_after_rst;
  int          dram_pending;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Response monitor: pops expected responses when they fall due.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (resp_q.size() > 0 && resp_q[0].due == cyc) begin
        resp_t e;
        e = resp_q.pop_front();
        chk("resp_valid", DW'(resp_valid), DW'(1) << e.id);
        chk("resp_data", resp_data, e.data);
      end else if (resp_valid !== '0) begin
        chk("resp_idle", DW'(resp_valid), '0);
      end
    end
  end

  // rvmode: 0 no return, 1 random return, 2 return whenever pending, 3 force pulse
  task automatic step(input logic [N-1:0] v, input bit rdy, input int rvmode, input bit r);
    logic [N-1:0] exp_gnt;
    bit           slot;
    int           idx;
    @(posedge clk);
    #1;
    rst       = r;
    req_valid = v;
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'($urandom);
    DRAM_Read_Ready = rdy && !r;
    DRAM_Read_Valid = 1'b0;
    for (int w = 0; w < DW/32; w++) DRAM_Read_Data[w*32 +: 32] = $urandom;
    if (!r) begin
      case (rvmode)
        1: DRAM_Read_Valid = (dram_pending > 0) && ($urandom_range(0, 2) != 0);
        2: DRAM_Read_Valid = (dram_pending > 0);
        3: DRAM_Read_Valid = 1'b1;
        default: DRAM_Read_Valid = 1'b0;
      endcase
      if (DRAM_Read_Valid && dram_pending > 0) dram_pending--;
    end
    @(negedge clk);
    if (r) begin
      m_ptr = 0; m_out = 0; m_en = 0; m_addr = '0; m_err = 0;
      m_after_rst = 1; dram_pending = 0;
      owner_q.delete();
      resp_q.delete();
      return;
    end

    chk("cmd_enable", DW'(DRAM_Read_Enable), DW'(m_en));
    if (m_en || m_after_rst) chk("cmd_addr", DW'(DRAM_Read_Addr), DW'(m_addr));
    chk("outstanding", DW'(outstanding), DW'(m_out));
    chk("err_unexpected", DW'(err_unexpected), DW'(m_err));
    m_after_rst = 0;

    slot    = (!m_en || rdy) && (m_out < MAXO);
    exp_gnt = '0;
    idx     = -1;
    if (slot) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (idx < 0 && v[c]) idx = c;
      end
    end
    if (idx >= 0) exp_gnt[idx] = 1'b1;
    chk("req_ready", DW'(req_ready), DW'(exp_gnt));

    if (m_en && rdy) dram_pending++;

    if (DRAM_Read_Valid) begin
      if (owner_q.size() > 0) begin
        resp_t e;
        e.due  = cyc + 1;
        e.id   = owner_q.pop_front();
        e.data = DRAM_Read_Data;
        resp_q.push_back(e);
        m_out--;
      end else begin
        m_err = 1;
      end
    end

    if (idx >= 0) begin
      m_en   = 1;
      m_addr = req_addr[idx*AW +: AW];
      owner_q.push_back(idx);
      m_ptr  = (idx + 1) % N;
      m_out++;
    end else if (rdy) begin
      m_en = 0;
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_addr = '0;
    DRAM_Read_Ready = 1'b0;
    DRAM_Read_Data = '0;
    DRAM_Read_Valid = 1'b0;
    dram_pending = 0;

    step('0, 0, 0, 1);
    step('0, 0, 0, 1);
    step('0, 1, 0, 0);

    // single requester, then drain
    repeat (4) step(2'b01, 1, 0, 0);
    repeat (8) step('0, 1, 2, 0);

    // both requesters compete; grants alternate
    repeat (6) step(2'b11, 1, 0, 0);
    repeat (10) step('0, 1, 2, 0);

    // DRAM backpressure on a pending command
    step(2'b11, 1, 0, 0);
    repeat (3) step(2'b11, 0, 0, 0);
    repeat (2) step(2'b11, 1, 0, 0);
    repeat (10) step('0, 1, 2, 0);

    // fill to the cap, release one slot, then drain
    repeat (20) step(2'b11, 1, 0, 0);
    step(2'b11, 1, 2, 0);
    repeat (3) step(2'b11, 1, 0, 0);
    repeat (30) step('0, 1, 2, 0);

    // stray return with nothing outstanding
    step('0, 1, 3, 0);
    repeat (3) step('0, 1, 0, 0);

    // reset with reads in flight and a command pending
    repeat (6) step(2'b01, 1, 0, 0);
    step(2'b01, 0, 0, 0);
    step('0, 0, 0, 1);
    repeat (3) step(2'b11, 1, 0, 0);
    repeat (10) step('0, 1, 2, 0);

    // randomized traffic
    for (int i = 0; i < 2000; i++)
      step(N'($urandom), ($urandom_range(0, 3) != 0), 1, 0);
    repeat (40) step('0, 1, 2, 0);

    chk("resp_queue_drained", DW'(resp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dram_read_arbiter.md
Name: dram_read_arbiter

Overview:
- Shares the single DRAM read command port between NUM_REQ requesters, for example the UDP readout address generator and a debug/host readback path.
- Arbitrates round-robin and issues one registered read command per cycle, holding it under DRAM backpressure.
- Tracks which requester owns each in-flight read in an in-order tag FIFO, and routes each returned 256-bit word back to its owner.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- ADDR_W, 25, DRAM read address width
- DATA_W, 256, DRAM read data width
- MAX_OUTSTANDING, 16, maximum reads accepted but not yet returned; power of two; sets tag FIFO depth
- ID_W, $clog2(NUM_REQ) (minimum 1), derived tag width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  NUM_REQ  per-requester read request
- req_addr  in  NUM_REQ*ADDR_W  request addresses; requester i occupies [i*ADDR_W +: ADDR_W]
- req_ready  out  NUM_REQ  one-hot grant; request i accepted when req_valid[i] && req_ready[i]
- DRAM_Read_Enable  out  1  command valid
- DRAM_Read_Addr  out  ADDR_W  command address
- DRAM_Read_Ready  in  1  DRAM accepts command this cycle when high with DRAM_Read_Enable
- DRAM_Read_Data  in  DATA_W  returned data, in command order
- DRAM_Read_Valid  in  1  returned data valid
- resp_valid  out  NUM_REQ  one-hot response strobe to the owning requester
- resp_data  out  DATA_W  registered response data, shared by all requesters
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  current in-flight count
- err_unexpected  out  1  sticky; set by a response arriving with the tag FIFO empty

Behaviour:
- Reset values:
  - all outputs 0
  - round-robin pointer 0
  - command register empty
  - tag FIFO empty
  - outstanding 0
  - reset mid-operation discards every pending command and tag; requesters must not see a stale resp_valid.
- Issue slot:
  - slot_free = (!DRAM_Read_Enable || DRAM_Read_Ready) && (outstanding < MAX_OUTSTANDING).
- Arbitration (combinational):
  - if slot_free, req_ready is one-hot on the first requester with req_valid, searching from pointer upward and wrapping modulo NUM_REQ; otherwise req_ready = 0.
  - req_ready never depends on the same requester's address.
- On acceptance of request i:
  - next cycle DRAM_Read_Enable=1 and DRAM_Read_Addr=req_addr[i]; latency request to command is 1 cycle.
  - tag i is pushed to the tag FIFO.
  - pointer becomes (i+1) mod NUM_REQ.
  - outstanding is incremented; it counts from acceptance, not from DRAM handshake.
- Backpressure:
  - while DRAM_Read_Enable && !DRAM_Read_Ready, the command is held stable and no new request is granted.
  - on the cycle it is taken, a new request may be accepted, giving back-to-back throughput of 1 command/cycle.
  - if no request is accepted, DRAM_Read_Enable drops to 0 the next cycle.
- Response routing:
  - on DRAM_Read_Valid with the tag FIFO non-empty: pop tag t; next cycle resp_valid = one-hot(t) for one cycle and resp_data = DRAM_Read_Data; outstanding is decremented.
  - response latency is 1 cycle.
- Simultaneous accept and response in one cycle: outstanding is unchanged; FIFO push and pop both occur, legal even when the FIFO is full or empty per counts.
- Cap: outstanding == MAX_OUTSTANDING forces req_ready=0. A response in the same cycle does not re-enable grant until the next cycle, because the cap check uses the registered count.
- Stray response: DRAM_Read_Valid with the tag FIFO empty:
  - data dropped, resp_valid stays 0
  - err_unexpected set, cleared only by rst
  - outstanding does not underflow.
- Width rules:
  - outstanding is one bit wider than the FIFO index, so the value MAX_OUTSTANDING is representable.
  - pointer arithmetic wraps modulo NUM_REQ, including non-power-of-two NUM_REQ.

Decomposition:
- Shared package dram_pkg:
  - DRAM_ADDR_W=25, DRAM_DATA_W=256
  - requester ID constants: REQ_UDP=0, REQ_HOST=1
  - typedef dram_cmd_t {addr}
- One sub-module, rd_tag_fifo:
  - synchronous FIFO, depth MAX_OUTSTANDING, width ID_W
  - push/pop with simultaneous-op support
  - full/empty flags and count

Test Plan:
- Single requester, 4 requests at addr 0x10..0x13 with DRAM_Read_Ready=1 -> commands on consecutive cycles 1 cycle after each accept; 4 data returns -> resp_valid=2'b01 four times, data unchanged, outstanding back to 0.
- Both requesters hold req_valid for 6 cycles -> grants alternate 0,1,0,1,0,1; returned words routed with resp_valid alternating 01/10 in the same order.
- DRAM_Read_Ready low 3 cycles with command addr 0x1ABCDE pending -> DRAM_Read_Addr stable 0x1ABCDE, req_ready=0 for those cycles; accepted on 4th cycle, next grant the same cycle.
- MAX_OUTSTANDING=16, no responses -> exactly 16 accepts then req_ready=0, outstanding=16; one DRAM_Read_Valid -> outstanding=15, grant resumes the following cycle.
- DRAM_Read_Valid pulse with nothing outstanding -> err_unexpected=1 and stays 1, resp_valid stays 0, outstanding stays 0.
- rst asserted with 5 reads outstanding and command pending -> next cycle all outputs 0, outstanding=0; a new request after rst is granted to requester 0 first.
